tc_fetch8: RTL and testbench
============================

# tc_fetch8

Instruction fetch stage for the 8-bit program path. Holds the program counter, drives the byte address of the program ROM (8-bit address, 8-bit data, combinational read), and captures each returned byte together with its address into a 2-entry buffer. The buffer presents instructions to the decode stage over a valid/ready handshake. Jump redirects, halt and wrap-around of the 8-bit address space are handled here.

## Interface
- ADDR_W, 8: program address width; the ROM holds 2^ADDR_W bytes.
- RESET_PC, 0: PC value loaded on reset.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_W  byte address to the program ROM; equals the PC register.
- rom_data  in  8  ROM byte at rom_addr, valid in the same cycle.
- jump_valid  in  1  redirect request, sampled each edge.
- jump_target  in  ADDR_W  new PC when jump_valid=1.
- halt  in  1  stop fetching, sampled each edge.
- instr_valid  out  1  buffer head is valid.
- instr  out  8  instruction byte at the buffer head; 0 when instr_valid=0.
- instr_pc  out  ADDR_W  address of instr; 0 when instr_valid=0.
- instr_ready  in  1  decode accepts the head this cycle.

## Operation
- Reset values: PC=RESET_PC, buffer count=0, state ST_RUN, instr_valid=0, instr=0, instr_pc=0, rom_addr=RESET_PC.
- States:
  - ST_RUN: fetching.
  - ST_HALT: no fetching. Leaves only on jump_valid.
- pop = instr_valid & instr_ready.
- push = (state==ST_RUN) & (count<2 | pop) & !jump_valid. Full with a same-cycle pop still pushes.
- Push writes {rom_data, PC} at the tail, and PC <= PC+1 modulo 2^ADDR_W. 255 wraps to 0 with no flag and no stall.
- Full with no pop: PC and rom_addr hold, and nothing is written.
- Jump (highest priority):
  - Buffer flushed to count=0, and any same-cycle pop is void.
  - PC <= jump_target, and the current rom_data is discarded.
  - Next state is ST_RUN, unless halt=1 in the same cycle, in which case it is ST_HALT.
- Halt without jump: the state goes to ST_HALT with no push that cycle. The buffer keeps draining through pops. PC holds.
- halt=1 while already in ST_HALT has no effect.
- jump_valid in ST_HALT: load PC, flush, and return to ST_RUN, or stay in ST_HALT if halt=1.
- Reset asserted mid-operation clears all state immediately. Buffered instructions are lost.

## Timing
- Address to instruction latency is 1 cycle. A byte fetched at edge n is at the head with instr_valid=1 after edge n.
- The first instruction is valid 1 cycle after rst deasserts.
- Throughput is 1 instruction/cycle with instr_ready held at 1. Count stays at 1, and the buffer never bubbles.
- Jump to first target instruction: instr_valid=0 for exactly 1 cycle after the jump edge, then the jump_target byte is at the head.
- instr_valid, instr and instr_pc are driven from registers only, with no combinational path from instr_ready.
- rom_addr is a register output.

## Structure
- Shared package tc_fetch8_pkg:
  - ADDR_W default.
  - State enum {ST_RUN, ST_HALT}.
  - Buffer entry struct {instr[7:0], pc[ADDR_W-1:0]}.
- Sub-module tc_fetch8_buf: 2-entry FIFO.
  - push/pop/flush inputs, with flush taking priority.
  - count 0..2 and registered head outputs, zeroed when empty.
- The top level holds the PC, the state register and the push/jump control.

## Test plan
- ROM holds bytes 0x00..0xFF equal to their address, instr_ready=1, release rst → instr_pc/instr = 0x00/0x00, 0x01/0x01, … one per cycle; after 0xFF the next is 0x00/0x00, wrapping without a gap.
- instr_ready=0 for 5 cycles after reset → count reaches 2 with rom_addr frozen at 0x02. With ready=1 again, outputs are 0x00, 0x01, 0x02 on consecutive cycles with no loss or duplication.
- Buffer full at PC=0x02, then jump_valid=1 with jump_target=0x40 while instr_ready=1 → the pop is void and the buffer is flushed. instr_valid=0 for 1 cycle, then instr_pc=0x40, 0x41, ….
- halt=1 at PC=0x10 with 2 entries buffered and ready=1 → both entries drain, then instr_valid stays 0 and rom_addr holds 0x10. A later jump to 0x80 resumes fetching with instr_pc=0x80.
- halt=1 and jump_valid=1 (target 0x20) on the same edge → rom_addr=0x20, the state is ST_HALT, and there is no instr_valid until a further jump.
- rst asserted asynchronously mid-stream with 2 entries buffered → instr_valid, instr and instr_pc are 0 immediately. rom_addr=RESET_PC. After release, fetching restarts from RESET_PC.

Source files
------------

// File: rtl/tc_fetch8_pkg.sv
// Shared types for the 8-bit fetch stage: default address width, fetch state
// and the buffered {instruction, address} entry.
package tc_fetch8_pkg;

  localparam int ADDR_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0]                instr;
    logic [ADDR_W_DEFAULT-1:0] pc;
  } entry_t;

endpackage

// File: rtl/tc_fetch8_buf.sv
// Two-entry instruction FIFO with flush priority and registered head outputs.
// Entries beyond the current count are held at zero, so an empty head reads zero.
module tc_fetch8_buf
  import tc_fetch8_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  entry_t     wr_entry,
  output logic [1:0] count,
  output logic       head_valid,
  output entry_t     head
);

  entry_t     ent0_q, ent0_d;
  entry_t     ent1_q, ent1_d;
  logic [1:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       pop_s;

  // Next-state of the two slots and occupancy
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    pop_s   = pop & (count_q != 2'd0);
    if (flush) begin
      ent0_d  = '0;
      ent1_d  = '0;
      count_d = 2'd0;
    end else begin
      case ({push, pop_s})
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_d = wr_entry;
          end else begin
            ent0_d = ent1_q;
            ent1_d = wr_entry;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            ent0_d  = wr_entry;
            count_d = 2'd1;
          end else if (count_q == 2'd1) begin
            ent1_d  = wr_entry;
            count_d = 2'd2;
          end else begin
            count_d = count_q;
          end
        end
        // slot 1 is already zero when count is 1, so shifting also clears the head
        2'b01: begin
          ent0_d  = ent1_q;
          ent1_d  = '0;
          count_d = count_q - 2'd1;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    valid_d = (count_d != 2'd0);
  end

  // Slot, count and head-valid registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  assign count      = count_q;
  assign head_valid = valid_q;
  assign head       = ent0_q;

endmodule

// File: rtl/tc_fetch8.sv
// Instruction fetch stage: PC, ROM addressing, jump/halt control and a
// two-entry buffer feeding decode over valid/ready.
module tc_fetch8
  import tc_fetch8_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              halt,
  output logic              instr_valid,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  state_e            state_q, state_d;
  logic              push_s, pop_s, flush_s;
  logic [1:0]        count_s;
  logic              head_valid_s;
  entry_t            head_s, wr_entry_s;

  assign pop_s            = head_valid_s & instr_ready;
  assign wr_entry_s.instr = rom_data;
  assign wr_entry_s.pc    = pc_q;

  // Fetch control: a jump overrides everything and voids any pop via flush
  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    push_s  = 1'b0;
    flush_s = 1'b0;
    if (jump_valid) begin
      flush_s = 1'b1;
      pc_d    = jump_target;
      state_d = halt ? ST_HALT : ST_RUN;
    end else if (state_q == ST_RUN) begin
      if (halt) begin
        state_d = ST_HALT;
      end else if ((count_s != 2'd2) || pop_s) begin
        push_s = 1'b1;
        pc_d   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        pc_d = pc_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // PC and fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  tc_fetch8_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (flush_s),
    .wr_entry   (wr_entry_s),
    .count      (count_s),
    .head_valid (head_valid_s),
    .head       (head_s)
  );

  assign rom_addr    = pc_q;
  assign instr_valid = head_valid_s;
  assign instr       = head_s.instr;
  assign instr_pc    = head_s.pc;

endmodule

// File: tb/tb_tc_fetch8.sv
// Self-checking bench for tc_fetch8: queue-based fetch model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_tc_fetch8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       jump_valid;
  logic [7:0] jump_target;
  logic       halt;
  logic       instr_valid;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_ready;

  logic [7:0] rom [256];

  typedef struct {
    logic [7:0] i;
    logic [7:0] p;
  } ment_t;

  ment_t      mq[$];
  logic [7:0] mpc;
  bit         mhalt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  tc_fetch8 dut (
    .clk         (clk),
    .rst         (rst),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .jump_valid  (jump_valid),
    .jump_target (jump_target),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mpc   = 8'h00;
    mhalt = 1'b0;
  endtask

  task automatic compare_all();
    logic       ev;
    logic [7:0] ei, ep;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].i : 8'h00;
    ep = ev ? mq[0].p : 8'h00;
    chk("rom_addr", rom_addr, mpc);
    chk("instr_valid", {7'b0, instr_valid}, {7'b0, ev});
    chk("instr", instr, ei);
    chk("instr_pc", instr_pc, ep);
  endtask

  // advance the model by one edge from the current inputs, then clock and compare
  task automatic step();
    ment_t e;
    bit    pop;
    if (rst) begin
      model_reset();
    end else begin
      pop = (mq.size() > 0) && instr_ready;
      if (jump_valid) begin
        mq.delete();
        mpc   = jump_target;
        mhalt = halt;
      end else begin
        if (pop) void'(mq.pop_front());
        if (!mhalt) begin
          if (halt) mhalt = 1'b1;
          else if (mq.size() < 2) begin
            e.i = rom[mpc];
            e.p = mpc;
            mq.push_back(e);
            mpc = mpc + 8'h01;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input logic rdy);
    rst = 1'b1;
    jump_valid = 1'b0;
    halt = 1'b0;
    instr_ready = rdy;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    jump_valid = 1'b0;
    jump_target = 8'h00;
    halt = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
    model_reset();
    #1;
    compare_all();
    chk("reset_rom_addr", rom_addr, 8'h00);
    chk("reset_valid", {7'b0, instr_valid}, 8'h00);

    // streaming with wrap-around
    do_reset(1'b1);
    for (int k = 1; k <= 258; k++) begin
      step();
      if (k == 1) chk("first_valid", {7'b0, instr_valid}, 8'h01);
      if (k == 1) chk("first_pc", instr_pc, 8'h00);
      if (k == 256) chk("pc_ff", instr_pc, 8'hFF);
      if (k == 257) chk("wrap_pc", instr_pc, 8'h00);
      if (k == 257) chk("wrap_instr", instr, 8'h00);
    end

    // back-pressure fills the buffer and freezes the address
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) step();
    chk("stall_rom_addr", rom_addr, 8'h02);
    chk("stall_head", instr_pc, 8'h00);
    instr_ready = 1'b1;
    step();
    chk("drain1", instr_pc, 8'h01);
    step();
    chk("drain2", instr_pc, 8'h02);

    // jump while full with a ready decode
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) step();
    jump_valid = 1'b1;
    jump_target = 8'h40;
    instr_ready = 1'b1;
    step();
    jump_valid = 1'b0;
    chk("jump_bubble", {7'b0, instr_valid}, 8'h00);
    chk("jump_addr", rom_addr, 8'h40);
    step();
    chk("jump_tgt", instr_pc, 8'h40);
    step();
    chk("jump_tgt1", instr_pc, 8'h41);

    // halt with two entries buffered
    do_reset(1'b0);
    jump_valid = 1'b1;
    jump_target = 8'h0E;
    step();
    jump_valid = 1'b0;
    step();
    step();
    chk("pre_halt_addr", rom_addr, 8'h10);
    halt = 1'b1;
    instr_ready = 1'b1;
    step();
    chk("halt_drain", instr_pc, 8'h0F);
    for (int k = 0; k < 4; k++) step();
    chk("halt_empty", {7'b0, instr_valid}, 8'h00);
    chk("halt_addr", rom_addr, 8'h10);
    halt = 1'b0;
    jump_valid = 1'b1;
    jump_target = 8'h80;
    step();
    jump_valid = 1'b0;
    step();
    chk("resume_pc", instr_pc, 8'h80);

    // jump and halt together
    halt = 1'b1;
    jump_valid = 1'b1;
    jump_target = 8'h20;
    step();
    halt = 1'b0;
    jump_valid = 1'b0;
    chk("jh_addr", rom_addr, 8'h20);
    for (int k = 0; k < 3; k++) step();
    chk("jh_idle", {7'b0, instr_valid}, 8'h00);
    chk("jh_addr_hold", rom_addr, 8'h20);
    jump_valid = 1'b1;
    jump_target = 8'h30;
    step();
    jump_valid = 1'b0;
    step();
    chk("jh_resume", instr_pc, 8'h30);

    // asynchronous reset mid-stream
    do_reset(1'b0);
    for (int k = 0; k < 3; k++) step();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_valid", {7'b0, instr_valid}, 8'h00);
    chk("arst_instr", instr, 8'h00);
    chk("arst_pc", instr_pc, 8'h00);
    chk("arst_addr", rom_addr, 8'h00);
    step();
    rst = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("arst_restart", instr_pc, 8'h00);

    // randomized traffic with random ROM contents
    rst = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_valid  = ($urandom_range(0, 15) == 0);
      jump_target = 8'($urandom);
      halt        = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
